// File: rtl/irs_readout_sequencer.sv
// irs_readout_sequencer: takes one block from the block FIFO and waits a
// programmable delay. It writes a header and the block into the event FIFO,
// starts each active daughter in turn and waits for its ready. It then frees
// the block and appends a trailer carrying this event's error flags.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            permits new events to start
//   block_dat_i/_empty_i/block_rd_o   block FIFO head (FWFT), empty, pop
//   irs_active_i        daughters present (captured as the event mask)
//   irs_rdy_i/irs_go_o  per-daughter ready in, one-hot go pulse out
//   event_space_i       free event-FIFO words
//   event_dat_o/_wr_o   event FIFO write port
//   free_block_o/free_req_o/free_ack_i  block free handshake
//   readout_delay_i     capture-to-header delay
//   readout_ready_o     idle and enabled
//   readout_err_o       sticky error flags (bit0 ready timeout,
//                       bit1 empty mask, bit2 free timeout)
module irs_readout_sequencer #(
  parameter int unsigned NUM_DAUGHTERS   = 4,
  parameter int unsigned BLOCK_WIDTH     = 72,
  parameter int unsigned BLOCK_ADDR_BITS = 9,
  parameter int unsigned TIMEOUT_BITS    = 16,
  parameter int unsigned MIN_SPACE       = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic [BLOCK_WIDTH-1:0]     block_dat_i,
  input  logic                       block_empty_i,
  output logic                       block_rd_o,
  input  logic [NUM_DAUGHTERS-1:0]   irs_active_i,
  input  logic [NUM_DAUGHTERS-1:0]   irs_rdy_i,
  output logic [NUM_DAUGHTERS-1:0]   irs_go_o,
  input  logic [15:0]                event_space_i,
  output logic [15:0]                event_dat_o,
  output logic                       event_wr_o,
  output logic [BLOCK_ADDR_BITS-1:0] free_block_o,
  output logic                       free_req_o,
  input  logic                       free_ack_i,
  input  logic [7:0]                 readout_delay_i,
  output logic                       readout_ready_o,
  output logic [7:0]                 readout_err_o
);

  localparam int unsigned NW        = (BLOCK_WIDTH + 15) / 16;
  localparam int unsigned WCNT_BITS = $clog2(NW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_HDR, S_GO, S_WAIT, S_FREE, S_TRAIL
  } state_e;

  state_e                     state_q, state_d;
  logic [NW*16-1:0]           blk_q, blk_d;
  logic [NUM_DAUGHTERS-1:0]   mask_q, mask_d;
  logic [NUM_DAUGHTERS-1:0]   pend_q, pend_d;
  logic [NUM_DAUGHTERS-1:0]   sel_q, sel_d;
  logic [7:0]                 dly_q, dly_d;
  logic [WCNT_BITS-1:0]       wcnt_q, wcnt_d;
  logic [TIMEOUT_BITS-1:0]    tmo_q, tmo_d;
  logic [2:0]                 flags_q, flags_d;
  logic [2:0]                 err_q, err_d;

  logic [NUM_DAUGHTERS-1:0]   low_oh;
  logic [11:0]                mask12;
  logic [15:0]                blk_word;
  logic                       start;

  always_comb begin
    low_oh = '0;
    for (int unsigned i = 0; i < NUM_DAUGHTERS; i++) begin
      if (pend_q[i] && (low_oh == '0)) low_oh[i] = 1'b1;
    end
  end

  always_comb begin
    mask12 = '0;
    mask12[NUM_DAUGHTERS-1:0] = mask_q;
  end

  // Header word k (k >= 1) is block slice k-1, lowest 16 bits first.
  always_comb begin
    blk_word = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (wcnt_q == WCNT_BITS'(i + 1)) blk_word = blk_q[i*16 +: 16];
    end
  end

  assign start = enable_i && !block_empty_i && (event_space_i >= 16'(MIN_SPACE));
  assign readout_err_o = {5'b0, err_q};

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    dly_d   = dly_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    flags_d = flags_q;
    err_d   = err_q;

    block_rd_o      = 1'b0;
    irs_go_o        = '0;
    event_dat_o     = '0;
    event_wr_o      = 1'b0;
    free_block_o    = '0;
    free_req_o      = 1'b0;
    readout_ready_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        readout_ready_o = enable_i && !rst_i;
        if (start && !rst_i) begin
          block_rd_o = 1'b1;
          blk_d      = '0;
          blk_d[BLOCK_WIDTH-1:0] = block_dat_i;
          mask_d     = irs_active_i;
          pend_d     = irs_active_i;
          dly_d      = readout_delay_i;
          flags_d    = '0;
          state_d    = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          wcnt_d  = '0;
          state_d = S_HDR;
        end else begin
          dly_d = dly_q - 8'd1;
        end
      end
      S_HDR: begin
        event_wr_o  = 1'b1;
        event_dat_o = (wcnt_q == '0) ? {4'hB, mask12} : blk_word;
        if (wcnt_q == WCNT_BITS'(NW)) state_d = S_GO;
        else                          wcnt_d  = wcnt_q + 1'b1;
      end
      S_GO: begin
        tmo_d = '0;
        if (pend_q != '0) begin
          irs_go_o = low_oh;
          sel_d    = low_oh;
          state_d  = S_WAIT;
        end else begin
          if (mask_q == '0) flags_d[1] = 1'b1;
          state_d = S_FREE;
        end
      end
      S_WAIT: begin
        // tmo_q is zero only in the cycle right after the go pulse, so a
        // ready seen then is ignored.
        if ((tmo_q != '0) && ((irs_rdy_i & sel_q) != '0)) begin
          pend_d  = pend_q & ~sel_q;
          state_d = S_GO;
        end else if (&tmo_q) begin
          flags_d[0] = 1'b1;
          pend_d     = pend_q & ~sel_q;
          state_d    = S_GO;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FREE: begin
        free_req_o   = 1'b1;
        free_block_o = blk_q[BLOCK_ADDR_BITS-1:0];
        if (free_ack_i) begin
          state_d = S_TRAIL;
        end else if (&tmo_q) begin
          flags_d[2] = 1'b1;
          state_d    = S_TRAIL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_TRAIL: begin
        event_wr_o  = 1'b1;
        event_dat_o = {8'hE0, 5'b0, flags_q};
        err_d       = err_q | flags_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      sel_q   <= '0;
      dly_q   <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      flags_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      dly_q   <= dly_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

endmodule
